// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA timing controller:
//   - default 640x480@60 timing (sync / back porch / active / front porch)
//   - line and frame totals and the active-window / request-window bounds
//     that follow from those defaults
//   - colour constants (RGB565) and the "no request" coordinate value
//   - small types used by the interface and the controller
// No ports (package).
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_VALID_DEF = 640;
  localparam int H_FRONT_DEF = 16;

  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_VALID_DEF = 480;
  localparam int V_FRONT_DEF = 10;

  localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
  localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;

  // Visible window (rgb_valid) for the default timing: h 144..783, v 35..514
  localparam int H_ACT_START = H_SYNC_DEF + H_BACK_DEF;
  localparam int H_ACT_END   = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF - 1;
  localparam int V_ACT_START = V_SYNC_DEF + V_BACK_DEF;
  localparam int V_ACT_END   = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF - 1;

  // Pixel request window leads the visible window by one clock: h 143..782
  localparam int H_REQ_START = H_ACT_START - 1;
  localparam int H_REQ_END   = H_ACT_END - 1;

  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  localparam logic [9:0]  COORD_INVALID = 10'h3FF;

  typedef logic [9:0]  coord_t;
  typedef logic [15:0] rgb565_t;

  // Scan sequencer: IDLE holds the counters at (0,0) while out of reset,
  // SCAN runs the raster.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/vga_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_ctrl_if
// Bundles the controller's pixel-request bus and display outputs.
//   pix_x / pix_y : requested coordinate, 10'h3FF when no request
//   pix_data      : RGB565 pixel returned one clock after the request
//   hsync / vsync : active-low sync
//   rgb           : pixel to the DAC, 0 outside the visible area
//   rgb_valid     : high during visible pixels
//   frame_tick / frame_cnt : only when VGA_CTRL_FRAME_TICK_EN is defined
// Modports:
//   master : the timing controller (drives coordinates, syncs and rgb)
//   slave  : the pixel generator / display side
// ----------------------------------------------------------------------------
interface vga_ctrl_if;
  import vga_pkg::*;

  coord_t  pix_x;
  coord_t  pix_y;
  rgb565_t pix_data;
  logic    hsync;
  logic    vsync;
  rgb565_t rgb;
  logic    rgb_valid;
`ifdef VGA_CTRL_FRAME_TICK_EN
  logic       frame_tick;
  logic [7:0] frame_cnt;
`endif

`ifdef VGA_CTRL_FRAME_TICK_EN
  modport master (
    input  pix_data,
    output pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_tick, frame_cnt
  );
  modport slave (
    output pix_data,
    input  pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_tick, frame_cnt
  );
`else
  modport master (
    input  pix_data,
    output pix_x, pix_y, hsync, vsync, rgb, rgb_valid
  );
  modport slave (
    output pix_data,
    input  pix_x, pix_y, hsync, vsync, rgb, rgb_valid
  );
`endif

endinterface

// File: rtl/vga_ctrl.sv
// ----------------------------------------------------------------------------
// vga_ctrl
// VGA raster timing controller. Two flat counters (cnt_h per clock, cnt_v per
// line) are decoded into active-low syncs, a one-clock-early pixel request
// (pix_x/pix_y) and the visible-pixel qualifier. The downstream generator
// registers its pixel, so the pixel it returns lines up with rgb_valid and is
// gated straight onto rgb.
//
// Ports:
//   vga_clk   : pixel clock
//   sys_rst_n : asynchronous active-low reset
//   vga       : vga_ctrl_if.master (pix_x, pix_y, pix_data, hsync, vsync,
//               rgb, rgb_valid [, frame_tick, frame_cnt])
//
// Optional feature: define VGA_CTRL_FRAME_TICK_EN to add frame_tick (pulse at
// the last clock of each frame) and an 8-bit wrapping frame_cnt.
// ----------------------------------------------------------------------------
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_VALID = H_VALID_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  vga_ctrl_if.master vga
);

  localparam int H_LEN = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_LEN = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam coord_t H_LAST   = coord_t'(H_LEN - 1);
  localparam coord_t V_LAST   = coord_t'(V_LEN - 1);
  localparam coord_t HS_END   = coord_t'(H_SYNC);
  localparam coord_t VS_END   = coord_t'(V_SYNC);
  localparam coord_t H_ACT_LO = coord_t'(H_SYNC + H_BACK);
  localparam coord_t H_ACT_HI = coord_t'(H_SYNC + H_BACK + H_VALID - 1);
  localparam coord_t H_REQ_LO = coord_t'(H_SYNC + H_BACK - 1);
  localparam coord_t H_REQ_HI = coord_t'(H_SYNC + H_BACK + H_VALID - 2);
  localparam coord_t V_ACT_LO = coord_t'(V_SYNC + V_BACK);
  localparam coord_t V_ACT_HI = coord_t'(V_SYNC + V_BACK + V_VALID - 1);

  scan_state_e state;
  scan_state_e state_nxt;
  logic        scan_en;

  coord_t cnt_h;
  coord_t cnt_v;
  logic   h_last;
  logic   v_last;
  logic   h_act;
  logic   h_req;
  logic   v_act;
  logic   pix_req;

  // Sequencer: the first clock after reset release only enters SCAN, so the
  // raster starts at (0,0) with hsync/vsync already low on that clock.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scan_en   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_SCAN;
      ST_SCAN: scan_en   = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign h_last = (cnt_h == H_LAST);
  assign v_last = (cnt_v == V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (scan_en) begin
      if (h_last) begin
        cnt_h <= '0;
        cnt_v <= v_last ? '0 : cnt_v + 10'd1;
      end else begin
        cnt_h <= cnt_h + 10'd1;
      end
    end
  end

  // Decode. Everything is qualified by scan_en so that reset forces the idle
  // output values immediately, without waiting for a clock.
  assign h_act   = (cnt_h >= H_ACT_LO) && (cnt_h <= H_ACT_HI);
  assign h_req   = (cnt_h >= H_REQ_LO) && (cnt_h <= H_REQ_HI);
  assign v_act   = (cnt_v >= V_ACT_LO) && (cnt_v <= V_ACT_HI);
  assign pix_req = scan_en && h_req && v_act;

  assign vga.hsync     = !scan_en || (cnt_h >= HS_END);
  assign vga.vsync     = !scan_en || (cnt_v >= VS_END);
  assign vga.rgb_valid = scan_en && h_act && v_act;
  assign vga.pix_x     = pix_req ? (cnt_h - H_REQ_LO) : COORD_INVALID;
  assign vga.pix_y     = pix_req ? (cnt_v - V_ACT_LO) : COORD_INVALID;
  assign vga.rgb       = vga.rgb_valid ? vga.pix_data : BLACK;

`ifdef VGA_CTRL_FRAME_TICK_EN
  logic [7:0] frame_cnt;

  assign vga.frame_tick = scan_en && h_last && v_last;
  assign vga.frame_cnt  = frame_cnt;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          frame_cnt <= '0;
    else if (vga.frame_tick) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 96, meaning the horizontal sync width in pixel clocks.
REQ-002 The block SHALL have parameter H_BACK, default 48, meaning the horizontal back porch in clocks.
REQ-003 The block SHALL have parameter H_VALID, default 640, meaning the active pixels per line.
REQ-004 The block SHALL have parameter H_FRONT, default 16, meaning the horizontal front porch in clocks.
REQ-005 The block SHALL have parameter V_SYNC, default 2, meaning the vertical sync width in lines.
REQ-006 The block SHALL have parameter V_BACK, default 33, meaning the vertical back porch in lines.
REQ-007 The block SHALL have parameter V_VALID, default 480, meaning the active lines.
REQ-008 The block SHALL have parameter V_FRONT, default 10, meaning the vertical front porch in lines.
REQ-009 The block SHALL have port vga_clk, input, 1 bit: pixel clock, nominally 25 MHz.
REQ-010 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-011 The block SHALL have port pix_data, input, 16 bits: RGB565 pixel returned by the downstream pixel generator, one clock after pix_x/pix_y.
REQ-012 The block SHALL have port pix_x, output, 10 bits: requested column 0..639; 10'h3FF when no request.
REQ-013 The block SHALL have port pix_y, output, 10 bits: requested row 0..479; 10'h3FF when no request.
REQ-014 The block SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-015 The block SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-016 The block SHALL have port rgb, output, 16 bits: pixel to the DAC; 0 outside the active area.
REQ-017 The block SHALL have port rgb_valid, output, 1 bit: high during visible pixels.

Function
REQ-018 cnt_h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters, 800) every clock and wrap to 0.
REQ-019 cnt_v SHALL increment only when cnt_h == H_TOTAL-1; it SHALL wrap 524 -> 0 (V_TOTAL = 525) on that same clock.
REQ-020 hsync SHALL be 0 for cnt_h in 0..H_SYNC-1 and 1 otherwise; vsync SHALL be 0 for cnt_v in 0..V_SYNC-1 and 1 otherwise.
REQ-021 rgb_valid SHALL be 1 iff cnt_h is in 144..783 and cnt_v is in 35..514; bounds SHALL be derived from the parameters.
REQ-022 pix_data_req SHALL run one clock ahead of rgb_valid: cnt_h in 143..782 with the same cnt_v window.
REQ-023 When pix_data_req = 1: pix_x = cnt_h-143 and pix_y = cnt_v-35, truncated to 10 bits; otherwise both SHALL be 10'h3FF.
REQ-024 rgb SHALL equal pix_data when rgb_valid = 1, else 16'h0000; the downstream registered pix_data is thereby aligned with zero extra latency.
REQ-025 Line boundary: at cnt_h = 799 the next clock SHALL show cnt_h = 0 and hsync = 0.
REQ-026 Frame boundary: at (799, 524) the next clock SHALL show (0, 0) with both hsync and vsync low.

Reset
REQ-027 While sys_rst_n = 0: cnt_h = cnt_v = 0, hsync = vsync = 1, rgb = 0, rgb_valid = 0, pix_x = pix_y = 10'h3FF.
REQ-028 Release SHALL restart the frame at (0, 0) on the first clock; reset asserted mid-frame SHALL abort the frame immediately with no partial-line completion.

Configuration
REQ-029 With VGA_CTRL_FRAME_TICK_EN defined, the block SHALL add output frame_tick (1 bit), a one-clock pulse when cnt_h = 799 and cnt_v = 524.
REQ-030 With VGA_CTRL_FRAME_TICK_EN defined, the block SHALL add output frame_cnt (8 bits), which increments on each frame_tick, wraps 255 -> 0 and resets to 0.
REQ-031 Without VGA_CTRL_FRAME_TICK_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Shared package vga_pkg SHALL hold the timing defaults, H_TOTAL/V_TOTAL, the derived active-window bounds, colour constants (GREEN = 16'h07E0, BLACK, WHITE) and the invalid-coordinate value 10'h3FF.
REQ-033 The block SHALL contain no sub-module; the two counters and the decode stay flat.

Verification
REQ-034 Scenario: after reset release, measure hsync -> period 800 clocks, low for exactly 96 clocks.
REQ-035 Scenario: vsync -> period 420000 clocks, low for 1600 clocks.
REQ-036 Scenario: drive pix_data = {pix_x[4:0], pix_y[5:0], pix_x[4:0]} from a registered model -> rgb at each visible pixel matches its own coordinate; exactly 307200 rgb_valid clocks per frame.
REQ-037 Scenario: at cnt_h = 143, cnt_v = 35 -> pix_x = 0, pix_y = 0; at cnt_h = 782, cnt_v = 514 -> pix_x = 639, pix_y = 479; at cnt_h = 783 -> pix_x = 10'h3FF.
REQ-038 Scenario: assert sys_rst_n low at cnt_h = 400, cnt_v = 200 -> outputs take their REQ-027 values asynchronously; after release, hsync falls on the first clock.
REQ-039 Scenario (with macro): run 257 frames -> 257 single-clock frame_tick pulses and frame_cnt = 1.
